// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// baud tick divider calculation used by both receive and transmit paths.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Rounded clocks-per-tick; never below one so the tick is always live.
  function automatic int calc_tick_div(input int clk_hz, input int baud, input int os);
    longint denom;
    longint div;
    denom = longint'(baud) * longint'(os);
    div   = (longint'(clk_hz) + denom / 2) / denom;
    if (div < 1) div = 1;
    return int'(div);
  endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Byte-side interface of the UART receiver. Port names mirror the
// receiver's external pin names.
//
// Handshake: o_valid rises with o_data and both hold steady until a rising
// edge sees o_valid && i_ready; that edge is the transfer. i_ready while
// o_valid is low has no effect. o_frame_err / o_overrun are single-cycle
// pulses outside the handshake.
interface uart_rx_byte_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_frame_err;
  logic                 o_overrun;
  logic                 o_busy;

  modport master (
    output o_data,
    output o_valid,
    input  i_ready,
    output o_frame_err,
    output o_overrun,
    output o_busy
  );

  modport slave (
    input  o_data,
    input  o_valid,
    output i_ready,
    input  o_frame_err,
    input  o_overrun,
    input  o_busy
  );

endinterface

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-cycle o_tick every DIV clocks, restartable
// through i_clear so the tick grid can be re-aligned to a line edge.
module uart_tick_gen #(
  parameter int DIV = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clear || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The clear cycle itself never ticks, so the first tick after a clear
  // lands DIV clocks later.
  assign o_tick = w_wrap && !i_clear;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronizes the raw line, oversamples each bit at its
// centre, and presents bytes on a valid/ready holding register.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_rx,
  uart_rx_byte_if.master io_bus,
  output rx_state_t o_dbg_state
);

  localparam int             TICK_DIV  = calc_tick_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int             OSW       = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] HALF_LAST = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] FULL_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_START = START;
  localparam logic [2:0] ST_DATA  = DATA;
  localparam logic [2:0] ST_STOP  = STOP;
  localparam logic [2:0] ST_BREAK = BREAK;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_rx_prev;
  logic [2:0]           r_state;
  logic [OSW-1:0]       r_os_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_pend;
  logic                 r_frame_err;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_overrun;

  logic w_rx_s;
  logic w_fall;
  logic w_clear;
  logic w_tick;
  logic w_half;
  logic w_full;
  logic w_accept;

  // Sync flops idle high so reset never looks like a start edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= i_rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  assign w_rx_s  = r_sync2;
  assign w_fall  = r_rx_prev && !w_rx_s;
  assign w_clear = (r_state == ST_IDLE) && w_fall;
  assign w_half  = w_tick && (r_os_cnt == HALF_LAST);
  assign w_full  = w_tick && (r_os_cnt == FULL_LAST);

  uart_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_os_cnt    <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_pend      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_pend      <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state  <= ST_START;
            r_os_cnt <= '0;
          end
        end
        ST_START: begin
          if (w_half) begin
            r_os_cnt  <= '0;
            r_bit_idx <= '0;
            // A high line at mid start bit was a glitch, not a frame.
            r_state   <= w_rx_s ? ST_IDLE : ST_DATA;
          end else if (w_tick) begin
            r_os_cnt <= r_os_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_full) begin
            r_os_cnt <= '0;
            r_shift  <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_idx == LAST_BIT) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else if (w_tick) begin
            r_os_cnt <= r_os_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_full) begin
            r_os_cnt <= '0;
            if (w_rx_s) begin
              r_pend  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_BREAK;
            end
          end else if (w_tick) begin
            r_os_cnt <= r_os_cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (w_rx_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_accept = r_valid && io_bus.i_ready;

  // Holding register: a new byte may replace one being accepted on the same
  // edge; otherwise a full register keeps its byte and flags the loss.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_pend) begin
        if (!r_valid || w_accept) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign io_bus.o_data      = r_data;
  assign io_bus.o_valid     = r_valid;
  assign io_bus.o_frame_err = r_frame_err;
  assign io_bus.o_overrun   = r_overrun;
  assign io_bus.o_busy      = (r_state != ST_IDLE);
  assign o_dbg_state        = rx_state_t'(r_state);

endmodule
